// File: rtl/teclado_eventos_pkg.sv
// Shared game package: key code width, debounce FSM encoding and the key codes
// consumed by the game FSM and the hero selector.
package teclado_eventos_pkg;

  localparam int KEY_W = 5;
  localparam int CNT_W = 24;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    HELD      = 2'd2,
    RELEASING = 2'd3
  } deb_state_t;

  localparam logic [KEY_W-1:0] KEY_NONE  = 5'd0;
  localparam logic [KEY_W-1:0] KEY_UP    = 5'd1;
  localparam logic [KEY_W-1:0] KEY_DOWN  = 5'd2;
  localparam logic [KEY_W-1:0] KEY_LEFT  = 5'd3;
  localparam logic [KEY_W-1:0] KEY_RIGHT = 5'd4;
  localparam logic [KEY_W-1:0] KEY_ENTER = 5'd16;
  localparam logic [KEY_W-1:0] KEY_BACK  = 5'd17;

  // Saturating increment: the debounce counter must never wrap back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + 24'd1;
    end
  endfunction

endpackage

// File: rtl/fifo_eventos.sv
// Show-ahead key event FIFO with registered head, occupancy and full flag.
// A push while full without a simultaneous pop is dropped and flagged on drop.
module fifo_eventos
  import teclado_eventos_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic                     valid,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wptr_r, rptr_r, wptr_n_s, rptr_n_s;
  logic [LW-1:0]    count_r, count_n_s, remain_s;
  logic             valid_r, full_r;
  logic [WIDTH-1:0] head_r, head_n_s;
  logic             pop_s, push_ok_s;

  // Next-state of pointers, occupancy and the show-ahead head word.
  always_comb begin
    pop_s     = valid_r & pop;
    push_ok_s = push & (~full_r | pop_s);
    drop      = push & full_r & ~pop_s;

    if (push_ok_s) begin
      wptr_n_s = wptr_r + AW'(1);
    end else begin
      wptr_n_s = wptr_r;
    end

    if (pop_s) begin
      rptr_n_s = rptr_r + AW'(1);
      remain_s = count_r - LW'(1);
    end else begin
      rptr_n_s = rptr_r;
      remain_s = count_r;
    end

    case ({push_ok_s, pop_s})
      2'b10:   count_n_s = count_r + LW'(1);
      2'b01:   count_n_s = count_r - LW'(1);
      default: count_n_s = count_r;
    endcase

    // When nothing older survives the pop, the word being written becomes the head.
    if (count_n_s == LW'(0)) begin
      head_n_s = {WIDTH{1'b0}};
    end else if (remain_s == LW'(0)) begin
      head_n_s = din;
    end else begin
      head_n_s = mem_r[rptr_n_s];
    end
  end

  // Storage array; contents are qualified by the pointers, so no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wptr_r] <= din;
    end
  end

  // Pointer and registered status update.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_r  <= AW'(0);
      rptr_r  <= AW'(0);
      count_r <= LW'(0);
      valid_r <= 1'b0;
      full_r  <= 1'b0;
      head_r  <= {WIDTH{1'b0}};
    end else begin
      wptr_r  <= wptr_n_s;
      rptr_r  <= rptr_n_s;
      count_r <= count_n_s;
      valid_r <= (count_n_s != LW'(0));
      full_r  <= (count_n_s == LW'(DEPTH));
      head_r  <= head_n_s;
    end
  end

  assign valid = valid_r;
  assign dout  = head_r;
  assign full  = full_r;
  assign level = count_r;

endmodule

// File: rtl/teclado_eventos.sv
// Keypad debouncer: turns each physical press into exactly one key event,
// queued in a small FIFO with a sticky overflow flag.
module teclado_eventos
  import teclado_eventos_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DEPTH           = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   keypad_pressed,
  input  logic [KEY_W-1:0]       key,
  output logic                   evt_valid,
  output logic [KEY_W-1:0]       evt_key,
  input  logic                   evt_ready,
  output logic                   lleno,
  output logic [$clog2(DEPTH):0] nivel,
  output logic                   overflow,
  input  logic                   clr_overflow
);

  localparam logic [CNT_W-1:0] DEB_TARGET = CNT_W'(DEBOUNCE_CYCLES);

  deb_state_t       state_r, state_n_s;
  logic [CNT_W-1:0] cnt_r, cnt_n_s;
  logic [KEY_W-1:0] cand_r, cand_n_s;
  logic             push_s, drop_s, overflow_r;

  // Debounce next-state: counts consecutive stable cycles on press and release.
  always_comb begin
    state_n_s = state_r;
    cnt_n_s   = cnt_r;
    cand_n_s  = cand_r;
    push_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (keypad_pressed) begin
          state_n_s = ARMING;
          cnt_n_s   = 24'd1;
          cand_n_s  = key;
        end else begin
          cnt_n_s   = 24'd0;
        end
      end
      ARMING: begin
        if (!keypad_pressed) begin
          state_n_s = IDLE;
          cnt_n_s   = 24'd0;
        end else if (key != cand_r) begin
          cnt_n_s   = 24'd1;
          cand_n_s  = key;
        end else if (cnt_r >= DEB_TARGET) begin
          state_n_s = HELD;
          push_s    = 1'b1;
        end else begin
          cnt_n_s   = sat_inc(cnt_r);
        end
      end
      HELD: begin
        if (!keypad_pressed) begin
          state_n_s = RELEASING;
          cnt_n_s   = 24'd1;
        end else begin
          state_n_s = HELD;
        end
      end
      RELEASING: begin
        if (keypad_pressed) begin
          state_n_s = HELD;
        end else if (cnt_r >= DEB_TARGET) begin
          state_n_s = IDLE;
          cnt_n_s   = 24'd0;
        end else begin
          cnt_n_s   = sat_inc(cnt_r);
        end
      end
      default: begin
        state_n_s = IDLE;
        cnt_n_s   = 24'd0;
        cand_n_s  = {KEY_W{1'b0}};
      end
    endcase
  end

  // Debounce state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 24'd0;
      cand_r  <= {KEY_W{1'b0}};
    end else begin
      state_r <= state_n_s;
      cnt_r   <= cnt_n_s;
      cand_r  <= cand_n_s;
    end
  end

  fifo_eventos #(
    .DEPTH (DEPTH),
    .WIDTH (KEY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .din   (cand_r),
    .pop   (evt_ready),
    .valid (evt_valid),
    .dout  (evt_key),
    .full  (lleno),
    .level (nivel),
    .drop  (drop_s)
  );

  // Sticky overflow: a new drop wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else if (clr_overflow) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  assign overflow = overflow_r;

endmodule
